appx_mult_ctrl: RTL and testbench

APPX_MULT_CTRL -- requirements
Module: appx_mult_ctrl

---
 rtl/appx_mult_pkg.sv | 29 ++
 rtl/lod16.sv | 36 +++
 rtl/appx_mult_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_appx_mult_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/appx_mult_pkg.sv
// ----------------------------------------------------------------------------
// appx_mult_pkg
//
// Purpose : Shared types and constants for the approximate multiplier
//           controller. Holds the FSM state encoding and the default operand
//           width / kept-mantissa-bits values used by appx_mult_ctrl and lod16.
//
// Contents:
//   state_t        - FSM states IDLE, ENC, MUL, OUT
//   DEFAULT_WIDTH  - default operand width in bits
//   DEFAULT_K      - default number of mantissa bits kept per operand
// ----------------------------------------------------------------------------
package appx_mult_pkg;

    // Default operand width in bits.
    localparam int DEFAULT_WIDTH = 16;

    // Default number of mantissa bits kept per operand after truncation.
    localparam int DEFAULT_K = 6;

    // Controller states. IDLE is the only state that accepts operands.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ENC  = 2'd1,
        ST_MUL  = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

endpackage : appx_mult_pkg

// File: rtl/lod16.sv
// ----------------------------------------------------------------------------
// lod16
//
// Purpose : Combinational leading-one detector. Reports the index of the
//           highest set bit of the input word and whether any bit is set.
//
// Ports:
//   vec_in   in  WIDTH            word to scan
//   position out $clog2(WIDTH)    index of the highest set bit (0 when zero)
//   nonzero  out 1                high when at least one bit of vec_in is set
// ----------------------------------------------------------------------------
module lod16
    import appx_mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0]         vec_in,
    output logic [$clog2(WIDTH)-1:0] position,
    output logic                     nonzero
);

    localparam int POS_W = $clog2(WIDTH);

    // Scan from LSB to MSB so the last hit, i.e. the highest set bit, wins.
    always_comb begin
        position = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (vec_in[i]) begin
                position = POS_W'(i);
            end
        end
    end

    assign nonzero = |vec_in;

endmodule : lod16

// File: rtl/appx_mult_ctrl.sv
// ----------------------------------------------------------------------------
// appx_mult_ctrl
//
// Purpose : Multi-cycle approximate unsigned multiplier. Each operand is
//           reduced to a K-bit mantissa starting at its leading one, the two
//           mantissas are multiplied exactly, and the product is shifted back
//           into place. Operands that already fit in K bits are kept exact.
//
//           Flow: IDLE (capture) -> ENC (truncate) -> MUL (multiply)
//                 -> OUT (present product, wait for consumer) -> IDLE
//
//           The product register is loaded on the first OUT cycle, so
//           out_valid rises on the third edge after the accepting edge no
//           matter what the operands are.
//
// Ports:
//   clk        in   1         clock, all registers update on the rising edge
//   rst        in   1         synchronous active-high reset
//   in_valid   in   1         operand pair present
//   in_ready   out  1         operand pair accepted this cycle (IDLE only)
//   a          in   WIDTH     unsigned operand A
//   b          in   WIDTH     unsigned operand B
//   out_valid  out  1         product valid
//   out_ready  in   1         consumer accepts the product
//   product    out  2*WIDTH   unsigned approximate product
//   busy       out  1         high whenever the FSM is not in IDLE
// ----------------------------------------------------------------------------
module appx_mult_ctrl
    import appx_mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int K     = DEFAULT_K
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    // Width of a leading-one position and of a per-operand shift amount.
    localparam int POS_W = $clog2(WIDTH);
    // Shift sum of both operands needs one extra bit.
    localparam int SH_W  = POS_W + 1;
    localparam int M_W   = 2 * K;
    localparam int P_W   = 2 * WIDTH;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    state_t             state_q,     state_d;
    logic [WIDTH-1:0]   a_q,         a_d;
    logic [WIDTH-1:0]   b_q,         b_d;
    logic [K-1:0]       ta_q,        ta_d;
    logic [K-1:0]       tb_q,        tb_d;
    logic [POS_W-1:0]   sa_q,        sa_d;
    logic [POS_W-1:0]   sb_q,        sb_d;
    logic [M_W-1:0]     m_q,         m_d;
    logic [SH_W-1:0]    sh_q,        sh_d;
    logic [P_W-1:0]     product_q,   product_d;
    logic               out_valid_q, out_valid_d;

    // Leading-one detector results for the captured operands.
    logic [POS_W-1:0]   pos_a;
    logic [POS_W-1:0]   pos_b;
    logic               nz_a;
    logic               nz_b;

    lod16 #(
        .WIDTH (WIDTH)
    ) u_lod_a (
        .vec_in   (a_q),
        .position (pos_a),
        .nonzero  (nz_a)
    );

    lod16 #(
        .WIDTH (WIDTH)
    ) u_lod_b (
        .vec_in   (b_q),
        .position (pos_b),
        .nonzero  (nz_b)
    );

    // ------------------------------------------------------------------------
    // Truncation helpers
    // ------------------------------------------------------------------------

    // Right-shift needed to bring the leading one down to bit K-1.
    // Operands whose leading one is already below bit K need no shift.
    function automatic logic [POS_W-1:0] trunc_shift(
        input logic [POS_W-1:0] p,
        input logic             nz
    );
        if (nz && (int'(p) >= K)) begin
            return POS_W'(int'(p) - K + 1);
        end
        return '0;
    endfunction

    // K-bit mantissa. When bits are dropped, bit 0 is forced high so the
    // truncated value sits near the middle of the discarded range instead
    // of always rounding down.
    function automatic logic [K-1:0] trunc_mant(
        input logic [WIDTH-1:0] x,
        input logic [POS_W-1:0] p,
        input logic             nz
    );
        logic [K-1:0] mant;
        if (!nz) begin
            return '0;
        end
        if (int'(p) >= K) begin
            mant    = K'(x >> trunc_shift(p, nz));
            mant[0] = 1'b1;
            return mant;
        end
        return x[K-1:0];
    endfunction

    // ------------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        ta_d        = ta_q;
        tb_d        = tb_q;
        sa_d        = sa_q;
        sb_d        = sb_q;
        m_d         = m_q;
        sh_d        = sh_q;
        product_d   = product_q;
        out_valid_d = out_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    state_d = ST_ENC;
                end
            end

            ST_ENC: begin
                ta_d    = trunc_mant(a_q, pos_a, nz_a);
                sa_d    = trunc_shift(pos_a, nz_a);
                tb_d    = trunc_mant(b_q, pos_b, nz_b);
                sb_d    = trunc_shift(pos_b, nz_b);
                state_d = ST_MUL;
            end

            ST_MUL: begin
                m_d     = M_W'(ta_q) * M_W'(tb_q);
                sh_d    = SH_W'(sa_q) + SH_W'(sb_q);
                state_d = ST_OUT;
            end

            ST_OUT: begin
                // First OUT cycle loads the product; afterwards it is held
                // until the consumer takes it. The width can never overflow
                // because the mantissa product plus the maximum shift is
                // exactly 2*WIDTH bits.
                if (!out_valid_q) begin
                    product_d   = P_W'(m_q) << sh_q;
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    product_d   = '0;
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers, reset to the idle/empty state
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            ta_q        <= '0;
            tb_q        <= '0;
            sa_q        <= '0;
            sb_q        <= '0;
            m_q         <= '0;
            sh_q        <= '0;
            product_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            ta_q        <= ta_d;
            tb_q        <= tb_d;
            sa_q        <= sa_d;
            sb_q        <= sb_d;
            m_q         <= m_d;
            sh_q        <= sh_d;
            product_q   <= product_d;
            out_valid_q <= out_valid_d;
        end
    end

    // in_ready depends on the state alone so a producer never sees a
    // combinational path from its own in_valid.
    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = out_valid_q;
    assign product   = product_q;

endmodule : appx_mult_ctrl

// File: tb/tb_appx_mult_ctrl.sv
// ----------------------------------------------------------------------------
// tb_appx_mult_ctrl
//
// Self-checking bench for appx_mult_ctrl with WIDTH=16, K=6. Expected
// products come from a table of hand-derived values plus a small reference
// model for random operands. Expected values are queued when an operand pair
// is accepted and popped when the product appears.
// ----------------------------------------------------------------------------
module tb_appx_mult_ctrl;

    localparam int WIDTH = 16;
    localparam int K     = 6;

    logic                clk;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [WIDTH-1:0]    a;
    logic [WIDTH-1:0]    b;
    logic                out_valid;
    logic                out_ready;
    logic [2*WIDTH-1:0]  product;
    logic                busy;

    appx_mult_ctrl #(
        .WIDTH (WIDTH),
        .K     (K)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0]   va;
        logic [WIDTH-1:0]   vb;
        logic [2*WIDTH-1:0] expected;
    } vector_t;

    vector_t            vectors[12];
    logic [2*WIDTH-1:0] expQueue[$];
    int                 nApplied;
    int                 nMiscompares;

    // Reference model: truncate each operand to a K-bit mantissa at its
    // leading one (bit 0 forced high when bits are dropped), multiply, and
    // shift back.
    function automatic logic [2*WIDTH-1:0] modelProduct(
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y
    );
        longint ops[2];
        longint mant[2];
        int     shift[2];
        int     lead;
        ops[0] = longint'(x);
        ops[1] = longint'(y);
        for (int k = 0; k < 2; k++) begin
            lead = -1;
            for (int i = 0; i < WIDTH; i++) begin
                if (ops[k][i]) lead = i;
            end
            if (lead >= K) begin
                shift[k] = lead - K + 1;
                mant[k]  = (ops[k] >> shift[k]) | 64'd1;
            end else begin
                shift[k] = 0;
                mant[k]  = ops[k];
            end
        end
        return (2*WIDTH)'((mant[0] * mant[1]) << (shift[0] + shift[1]));
    endfunction

    // Single comparison point: counts every comparison and reports misses.
    task automatic checkOutput(
        input string       name,
        input logic [63:0] actual,
        input logic [63:0] expected
    );
        nApplied++;
        if (actual !== expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Present one operand pair, wait (bounded) for acceptance and queue the
    // expected product on the accepting edge.
    task automatic applyStimulus(
        input logic [WIDTH-1:0]   va,
        input logic [WIDTH-1:0]   vb,
        input logic [2*WIDTH-1:0] expected
    );
        int waited;
        waited = 0;
        while (!in_ready && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            checkOutput("in_ready_timeout", 64'(in_ready), 64'd1);
        end
        in_valid = 1'b1;
        a        = va;
        b        = vb;
        @(posedge clk);
        expQueue.push_back(expected);
        #1;
        in_valid = 1'b0;
    endtask

    // Count edges from the accepting edge until out_valid is seen.
    task automatic waitForOutput(output int latency);
        latency = 0;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                latency = n;
                break;
            end
        end
    endtask

    // Pop the oldest expected product and compare against the DUT output.
    task automatic checkProduct(input string name, output logic [2*WIDTH-1:0] expected);
        if (expQueue.size() == 0) begin
            expected = '0;
            checkOutput({name, "_queue_empty"}, 64'd0, 64'd1);
        end else begin
            expected = expQueue.pop_front();
            checkOutput(name, 64'(product), 64'(expected));
        end
    endtask

    // Accept the product and confirm the block is back in IDLE.
    task automatic completeHandshake(input string name);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput({name, "_idle"}, {62'd0, in_ready, out_valid}, {62'd0, 1'b1, 1'b0});
    endtask

    // Full transaction: apply, check latency and product, hand off.
    task automatic runTransaction(
        input string              name,
        input logic [WIDTH-1:0]   va,
        input logic [WIDTH-1:0]   vb,
        input logic [2*WIDTH-1:0] expected
    );
        int                 latency;
        logic [2*WIDTH-1:0] popped;
        applyStimulus(va, vb, expected);
        waitForOutput(latency);
        checkOutput({name, "_latency"}, 64'(latency), 64'd3);
        checkProduct({name, "_product"}, popped);
        completeHandshake(name);
    endtask

    initial begin
        int                 latency;
        logic [2*WIDTH-1:0] held;
        logic [WIDTH-1:0]   ra;
        logic [WIDTH-1:0]   rb;

        nApplied     = 0;
        nMiscompares = 0;

        vectors[0]  = '{16'd3,      16'd5,      32'd15};
        vectors[1]  = '{16'hFFFF,   16'hFFFF,   32'hF810_0000};
        vectors[2]  = '{16'h0100,   16'h0020,   32'd8448};
        vectors[3]  = '{16'd0,      16'd1234,   32'd0};
        vectors[4]  = '{16'd1234,   16'd0,      32'd0};
        vectors[5]  = '{16'd63,     16'd63,     32'd3969};
        vectors[6]  = '{16'd64,     16'd64,     32'd4356};
        vectors[7]  = '{16'd1,      16'd1,      32'd1};
        vectors[8]  = '{16'h8000,   16'd2,      32'd67584};
        vectors[9]  = '{16'd100,    16'd37,     32'd3774};
        vectors[10] = '{16'd7,      16'd9,      32'd63};
        vectors[11] = '{16'd0,      16'd0,      32'd0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] checking reset state");
        checkOutput("reset_in_ready",  64'(in_ready),  64'd1);
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_busy",      64'(busy),      64'd0);
        checkOutput("reset_product",   64'(product),   64'd0);

        $display("[TB] table vectors");
        for (int i = 0; i < 12; i++) begin
            runTransaction($sformatf("vec%0d", i), vectors[i].va, vectors[i].vb, vectors[i].expected);
        end

        $display("[TB] random vectors against reference model");
        for (int i = 0; i < 8; i++) begin
            ra = WIDTH'($urandom_range(0, 65535));
            rb = WIDTH'($urandom_range(0, 65535));
            runTransaction($sformatf("rnd%0d", i), ra, rb, modelProduct(ra, rb));
        end

        $display("[TB] output stall with new operands offered");
        applyStimulus(16'd3, 16'd5, 32'd15);
        waitForOutput(latency);
        checkOutput("stall_latency", 64'(latency), 64'd3);
        checkProduct("stall_product", held);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a         = 16'hFFFF;
        b         = 16'hFFFF;
        for (int n = 0; n < 5; n++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("stall%0d_product", n), 64'(product), 64'(held));
            checkOutput($sformatf("stall%0d_valid_ready", n),
                        {62'd0, out_valid, in_ready}, {62'd0, 1'b1, 1'b0});
        end
        in_valid = 1'b0;
        completeHandshake("stall");
        checkOutput("stall_busy_after", 64'(busy), 64'd0);

        $display("[TB] reset while in MUL");
        in_valid = 1'b1;
        a        = 16'hFFFF;
        b        = 16'd3;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("mulrst_enc_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("mulrst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("mulrst_in_ready",  64'(in_ready),  64'd1);
        checkOutput("mulrst_busy",      64'(busy),      64'd0);
        checkOutput("mulrst_product",   64'(product),   64'd0);
        runTransaction("post_rst", 16'd7, 16'd9, 32'd63);

        $display("[TB] reset and in_valid on the same edge");
        rst      = 1'b1;
        in_valid = 1'b1;
        a        = 16'd5;
        b        = 16'd5;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        checkOutput("rstwin_busy", 64'(busy), 64'd0);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("rstwin_no_output", 64'(out_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiscompares);
        $finish;
    end

endmodule : tb_appx_mult_ctrl
